// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard-control unit for the 5-stage pipeline.
// Selects EX-stage operand sources for NUM_SRC read ports, detects load-use
// and MDU hazards, tracks one outstanding multi-cycle (MDU) operation and
// keeps a saturating count of stalled cycles for performance monitoring.
module fwd_hazard_unit #(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int LAT_W   = 4,
  parameter int SC_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // EX/MEM and MEM/WB writers
  input  logic                   ex_mem_reg_write,
  input  logic [AW-1:0]          ex_mem_rd,
  input  logic                   mem_wb_reg_write,
  input  logic [AW-1:0]          mem_wb_rd,
  // EX-stage instruction
  input  logic [NUM_SRC*AW-1:0]  id_ex_rs,
  input  logic                   id_ex_mem_read,
  input  logic [AW-1:0]          id_ex_rd,
  // ID-stage instruction
  input  logic [NUM_SRC*AW-1:0]  id_rs,
  input  logic [NUM_SRC-1:0]     id_rs_valid,
  input  logic [AW-1:0]          id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_is_mdu,
  // MDU op entering execution
  input  logic                   mdu_issue,
  input  logic [AW-1:0]          mdu_rd,
  input  logic [LAT_W-1:0]       mdu_lat,
  // Controls and status
  output logic [2*NUM_SRC-1:0]   fwd_sel,
  output logic                   stall,
  output logic                   mdu_busy,
  output logic                   mdu_done,
  output logic [AW-1:0]          mdu_done_rd,
  output logic [SC_W-1:0]        stall_cnt
);

  // Scoreboard state for the single outstanding MDU op
  logic             busy_q, busy_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic             done_q, done_d;
  logic [AW-1:0]    done_rd_q, done_rd_d;
  logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic last_cycle;  // final busy cycle of the outstanding op
  logic accept;      // MDU issue taken on the coming edge
  logic src_hit;     // some valid ID source collides with a pending writer
  logic waw_hit;
  logic struct_hit;

  assign last_cycle = busy_q && (cnt_q == LAT_W'(1));
  assign accept     = mdu_issue && (!busy_q || last_cycle);

  // Per-source forward select: MDU completion beats EX/MEM beats MEM/WB
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and a latch is never inferred.
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_ex_rs[i*AW +: AW] != '0) begin
        if (done_q && (done_rd_q == id_ex_rs[i*AW +: AW])) begin
          fwd_sel[2*i +: 2] = 2'b11;
        end else if (ex_mem_reg_write && (ex_mem_rd == id_ex_rs[i*AW +: AW])) begin
          fwd_sel[2*i +: 2] = 2'b10;
        end else if (mem_wb_reg_write && (mem_wb_rd == id_ex_rs[i*AW +: AW])) begin
          fwd_sel[2*i +: 2] = 2'b01;
        end
      end
    end
  end

  // RAW collisions of valid, nonzero ID sources with in-flight writers
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_valid[i] && (id_rs[i*AW +: AW] != '0)) begin
        if (id_ex_mem_read && (id_rs[i*AW +: AW] == id_ex_rd)) src_hit = 1'b1;
        if (busy_q && (id_rs[i*AW +: AW] == rd_q))             src_hit = 1'b1;
        // The regfile write of a completing MDU op lands at the end of the
        // done cycle, so the ID read in that cycle would still see stale data.
        if (done_q && (id_rs[i*AW +: AW] == done_rd_q))        src_hit = 1'b1;
      end
    end
  end

  // A younger writer of the MDU destination must wait so the MDU op stays
  // the youngest writer of rd_q, which is what makes MDU forwarding safe.
  assign waw_hit    = busy_q && id_reg_write && (id_rd != '0) && (id_rd == rd_q);
  // A new MDU op can only enter on the last busy cycle of the current one.
  assign struct_hit = id_is_mdu && busy_q && !last_cycle;
  assign stall      = src_hit || waw_hit || struct_hit;

  // Scoreboard next state: accept, count down, retire with a done pulse
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    done_d    = last_cycle;
    done_rd_d = last_cycle ? rd_q : done_rd_q;
    if (accept) begin
      busy_d = 1'b1;
      cnt_d  = (mdu_lat == '0) ? LAT_W'(1) : mdu_lat;
      rd_d   = mdu_rd;
    end else if (busy_q) begin
      if (last_cycle) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - LAT_W'(1);
      end
    end
  end

  // Saturating stall counter next state
  assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + SC_W'(1)
                                                      : stall_cnt_q;

  // Scoreboard registers; reset discards any pending op without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      done_rd_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      done_rd_q <= done_rd_d;
    end
  end

  // Performance counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mdu_busy    = busy_q;
  assign mdu_done    = done_q;
  assign mdu_done_rd = done_rd_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios followed by
// random traffic, all compared against a cycle-indexed behavioural model.
module tb_fwd_hazard_unit;

  localparam int NUM_SRC = 2;
  localparam int AW      = 5;
  localparam int LAT_W   = 4;
  localparam int SC_W    = 4;
  localparam int SC_MAX  = (1 << SC_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  ex_mem_reg_write, mem_wb_reg_write;
  logic [AW-1:0]         ex_mem_rd, mem_wb_rd;
  logic [NUM_SRC*AW-1:0] id_ex_rs, id_rs;
  logic                  id_ex_mem_read;
  logic [AW-1:0]         id_ex_rd, id_rd, mdu_rd;
  logic [NUM_SRC-1:0]    id_rs_valid;
  logic                  id_reg_write, id_is_mdu, mdu_issue;
  logic [LAT_W-1:0]      mdu_lat;
  logic [2*NUM_SRC-1:0]  fwd_sel;
  logic                  stall, mdu_busy, mdu_done;
  logic [AW-1:0]         mdu_done_rd;
  logic [SC_W-1:0]       stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .AW(AW), .LAT_W(LAT_W), .SC_W(SC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
    .id_ex_rs(id_ex_rs), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .id_rs(id_rs), .id_rs_valid(id_rs_valid), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_mdu(id_is_mdu),
    .mdu_issue(mdu_issue), .mdu_rd(mdu_rd), .mdu_lat(mdu_lat),
    .fwd_sel(fwd_sel), .stall(stall), .mdu_busy(mdu_busy),
    .mdu_done(mdu_done), .mdu_done_rd(mdu_done_rd), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: ops are described by the cycle in which they complete.
  // "now" counts clock edges since reset; an op accepted on the edge taken
  // while now==n is busy for cycles n+1..n+L and done in cycle n+L+1.
  typedef struct {
    int            c;
    logic [AW-1:0] rd;
  } done_t;

  int            now;
  bit            op_v;
  int            op_end;
  logic [AW-1:0] op_rd;
  done_t         dq[$];
  int            sc;

  function automatic bit m_busy();
    return op_v && (now < op_end);
  endfunction

  function automatic int m_rem();
    return op_end - now;
  endfunction

  function automatic bit m_done();
    foreach (dq[k]) if (dq[k].c == now) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [AW-1:0] m_done_rd();
    foreach (dq[k]) if (dq[k].c == now) return dq[k].rd;
    return '0;
  endfunction

  function automatic logic [2*NUM_SRC-1:0] m_fwd();
    logic [2*NUM_SRC-1:0] r = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [AW-1:0] rs = id_ex_rs[i*AW +: AW];
      if (rs != 0) begin
        if (m_done() && m_done_rd() == rs)           r[2*i +: 2] = 2'b11;
        else if (ex_mem_reg_write && ex_mem_rd == rs) r[2*i +: 2] = 2'b10;
        else if (mem_wb_reg_write && mem_wb_rd == rs) r[2*i +: 2] = 2'b01;
      end
    end
    return r;
  endfunction

  function automatic bit m_stall();
    bit s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [AW-1:0] rs = id_rs[i*AW +: AW];
      if (id_rs_valid[i] && rs != 0) begin
        if (id_ex_mem_read && rs == id_ex_rd) s = 1'b1;
        if (m_busy() && rs == op_rd)          s = 1'b1;
        if (m_done() && rs == m_done_rd())    s = 1'b1;
      end
    end
    if (m_busy() && id_reg_write && id_rd != 0 && id_rd == op_rd) s = 1'b1;
    if (id_is_mdu && m_busy() && m_rem() != 1)                     s = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    now  = 0;
    op_v = 1'b0;
    dq.delete();
    sc   = 0;
  endtask

  task automatic model_edge();
    int L;
    if (m_stall() && sc < SC_MAX) sc++;
    if (mdu_issue && (!m_busy() || m_rem() == 1)) begin
      L      = (mdu_lat == 0) ? 1 : int'(mdu_lat);
      op_v   = 1'b1;
      op_end = now + 1 + L;
      op_rd  = mdu_rd;
      dq.push_back('{c: op_end, rd: mdu_rd});
    end
    now++;
    while (dq.size() > 0 && dq[0].c < now) void'(dq.pop_front());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  task automatic check_all();
    check("fwd_sel",   32'(fwd_sel),  32'(m_fwd()));
    check("stall",     32'(stall),    32'(m_stall()));
    check("mdu_busy",  32'(mdu_busy), 32'(m_busy()));
    check("mdu_done",  32'(mdu_done), 32'(m_done()));
    if (m_done()) check("mdu_done_rd", 32'(mdu_done_rd), 32'(m_done_rd()));
    check("stall_cnt", 32'(stall_cnt), 32'(sc));
  endtask

  // Advance one clock: model follows the edge, inputs change after negedge
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    ex_mem_reg_write = 1'b0; ex_mem_rd = '0;
    mem_wb_reg_write = 1'b0; mem_wb_rd = '0;
    id_ex_rs = '0; id_ex_mem_read = 1'b0; id_ex_rd = '0;
    id_rs = '0; id_rs_valid = '0; id_rd = '0;
    id_reg_write = 1'b0; id_is_mdu = 1'b0;
    mdu_issue = 1'b0; mdu_rd = '0; mdu_lat = '0;
  endtask

  initial begin
    // Reset state
    set_idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check("rst_busy", 32'(mdu_busy), 0);
    check("rst_done", 32'(mdu_done), 0);
    check("rst_cnt",  32'(stall_cnt), 0);
    check_all();
    rst_n = 1'b1;
    tick();

    // Forward priority
    ex_mem_reg_write = 1'b1; mem_wb_reg_write = 1'b1;
    ex_mem_rd = 5; mem_wb_rd = 5; id_ex_rs[0 +: AW] = 5;
    #1 check("fwd_exmem", 32'(fwd_sel[1:0]), 32'b10); check_all();
    ex_mem_reg_write = 1'b0;
    #1 check("fwd_memwb", 32'(fwd_sel[1:0]), 32'b01); check_all();
    ex_mem_reg_write = 1'b1; id_ex_rs[0 +: AW] = 0; ex_mem_rd = 0; mem_wb_rd = 0;
    #1 check("fwd_r0", 32'(fwd_sel[1:0]), 32'b00); check_all();
    tick();

    // Load-use: three stalled cycles, then an invalid source does not stall
    set_idle();
    id_ex_mem_read = 1'b1; id_ex_rd = 7; id_rs[AW +: AW] = 7; id_rs_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1 check("load_use", 32'(stall), 1); check_all();
      tick();
    end
    check("lu_cnt", 32'(stall_cnt), 3);
    id_rs_valid = 2'b00;
    #1 check("lu_invalid", 32'(stall), 0); check_all();
    tick();

    // MDU latency 3 to rd 9, dependent ID source stalls through done
    set_idle();
    mdu_issue = 1'b1; mdu_rd = 9; mdu_lat = 3;
    #1 check_all();
    tick();
    set_idle();
    id_rs[0 +: AW] = 9; id_rs_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1 check("lat_busy", 32'(mdu_busy), 1); check("lat_stall", 32'(stall), 1); check_all();
      tick();
    end
    id_ex_rs[0 +: AW] = 9; ex_mem_reg_write = 1'b1; ex_mem_rd = 9;
    #1 check("lat_done", 32'(mdu_done), 1); check("lat_done_rd", 32'(mdu_done_rd), 9);
    check("lat_fwd", 32'(fwd_sel[1:0]), 32'b11); check("lat_done_stall", 32'(stall), 1);
    check("lat_idle", 32'(mdu_busy), 0); check_all();
    tick();
    set_idle();
    #1 check("lat_pulse", 32'(mdu_done), 0); check_all();
    tick();

    // WAW, structural, and back-to-back issue on the last busy cycle
    mdu_issue = 1'b1; mdu_rd = 4; mdu_lat = 4;
    #1 check_all();
    tick();
    set_idle();
    id_rd = 4; id_reg_write = 1'b1;
    #1 check("waw", 32'(stall), 1); check_all();
    id_reg_write = 1'b0; id_is_mdu = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check("struct", 32'(stall), 1); check_all();
      tick();
    end
    #1 check("struct_free", 32'(stall), 0); check_all();
    mdu_issue = 1'b1; mdu_rd = 6; mdu_lat = 2;
    #1 check_all();
    tick();
    set_idle();
    #1 check("b2b_busy", 32'(mdu_busy), 1); check("b2b_done", 32'(mdu_done), 1);
    check("b2b_done_rd", 32'(mdu_done_rd), 4); check_all();
    for (int k = 0; k < 4; k++) begin
      tick();
      #1 check_all();
    end

    // Reset in the middle of a long op
    mdu_issue = 1'b1; mdu_rd = 3; mdu_lat = 10;
    #1 check_all();
    tick();
    set_idle();
    for (int k = 0; k < 2; k++) begin
      #1 check_all();
      tick();
    end
    rst_n = 1'b0;
    #1 model_reset();
    check("mid_rst_busy", 32'(mdu_busy), 0);
    check("mid_rst_cnt",  32'(stall_cnt), 0);
    check_all();
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1 check("no_done", 32'(mdu_done), 0); check_all();
      tick();
    end

    // Saturation of the stall counter
    id_ex_mem_read = 1'b1; id_ex_rd = 2; id_rs[0 +: AW] = 2; id_rs_valid = 2'b01;
    for (int k = 0; k < 20; k++) begin
      #1 check_all();
      tick();
    end
    #1 check("sat", 32'(stall_cnt), 32'(SC_MAX));

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      ex_mem_reg_write = 1'($urandom_range(0, 1));
      mem_wb_reg_write = 1'($urandom_range(0, 1));
      ex_mem_rd        = AW'($urandom_range(0, 7));
      mem_wb_rd        = AW'($urandom_range(0, 7));
      for (int i = 0; i < NUM_SRC; i++) begin
        id_ex_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
        id_rs[i*AW +: AW]    = AW'($urandom_range(0, 7));
      end
      id_rs_valid    = NUM_SRC'($urandom_range(0, (1 << NUM_SRC) - 1));
      id_ex_mem_read = ($urandom_range(0, 3) == 0);
      id_ex_rd       = AW'($urandom_range(0, 7));
      id_rd          = AW'($urandom_range(0, 7));
      id_reg_write   = 1'($urandom_range(0, 1));
      id_is_mdu      = ($urandom_range(0, 3) == 0);
      mdu_issue      = ($urandom_range(0, 2) == 0);
      mdu_rd         = AW'($urandom_range(0, 7));
      mdu_lat        = ($urandom_range(0, 9) == 0) ? LAT_W'(15) : LAT_W'($urandom_range(0, 5));
      #1 check_all();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard-control unit for the 5-stage pipeline, generalising EX-stage operand forwarding to NUM_SRC read ports. It adds load-use stall detection and a scoreboard for one outstanding multi-cycle (MDU) operation. The MDU result is forwarded in its completion cycle. A saturating stall counter is kept for performance monitoring. Sits beside the ID/EX register, driving operand muxes and the pipeline stall line.

## Interface
- NUM_SRC, 2, source operands per instruction
- AW, 5, register address width
- LAT_W, 4, MDU latency field width (max latency 2^LAT_W-1)
- SC_W, 32, stall counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_mem_reg_write, ex_mem_rd  in  1, AW  EX/MEM writer
- mem_wb_reg_write, mem_wb_rd  in  1, AW  MEM/WB writer
- id_ex_rs  in  NUM_SRC*AW  EX-stage sources, src i at [i*AW +: AW]
- id_ex_mem_read, id_ex_rd  in  1, AW  EX-stage load and destination
- id_rs, id_rs_valid  in  NUM_SRC*AW, NUM_SRC  ID-stage sources and per-source valid
- id_rd, id_reg_write, id_is_mdu  in  AW, 1, 1  ID-stage destination, write enable, MDU-op flag
- mdu_issue, mdu_rd, mdu_lat  in  1, AW, LAT_W  MDU op entering execution
- fwd_sel  out  2*NUM_SRC  per-source select, src i at [2i +: 2]
- stall  out  1  hold PC and IF/ID, bubble into ID/EX
- mdu_busy  out  1  MDU op outstanding
- mdu_done, mdu_done_rd  out  1, AW  registered completion pulse and destination
- stall_cnt  out  SC_W  saturating count of stalled cycles

## Operation
- Forward select per source i (combinational; register 0 never matches):
  - 11: mdu_done and mdu_done_rd == id_ex_rs[i].
  - Else 10: ex_mem_reg_write, ex_mem_rd == rs.
  - Else 01: mem_wb_reg_write, mem_wb_rd == rs.
  - Else 00.
  - Priority MDU > EX/MEM > MEM/WB. The MDU op is always the youngest writer of its rd while pending, because the WAW stall holds younger writers.
- Scoreboard: registers busy, cnt[LAT_W], rd_q[AW].
  - Issue accepted when mdu_issue and (!busy or cnt==1).
  - On accept: busy<=1, cnt<=max(mdu_lat,1), rd_q<=mdu_rd.
  - While busy without accept: cnt==1 gives busy<=0; otherwise cnt<=cnt-1.
  - cnt==1 also gives mdu_done<=1 and mdu_done_rd<=rd_q next cycle, even if a new issue is accepted on the same edge.
  - mdu_done is otherwise 0.
  - mdu_issue while busy and cnt!=1 is ignored (state unchanged).
- stall = OR of the following (only valid sources and nonzero registers count):
  - load-use: id_ex_mem_read and any id_rs == id_ex_rd.
  - MDU RAW: busy and any id_rs == rd_q.
  - MDU WAW: busy, id_reg_write, id_rd == rd_q.
  - MDU done RAW: mdu_done and any id_rs == mdu_done_rd. The regfile write lands at the end of the done cycle.
  - MDU structural: id_is_mdu, busy, cnt != 1.
- stall_cnt increments by 1 every cycle stall==1 and holds at all-ones.

## Timing
- Reset (async, rst_n low): busy=0, cnt=0, rd_q=0, mdu_done=0, mdu_done_rd=0, stall_cnt=0, mdu_busy=0.
  - fwd_sel and stall follow inputs with busy=0 (load-use only).
- Reset mid-operation discards the pending MDU op with no done pulse.
- fwd_sel and stall are combinational from inputs and current state, with zero latency.
- Issue with latency L at edge E:
  - mdu_busy is high for exactly L cycles after E.
  - mdu_done is high for the single cycle after that.
  - mdu_lat=0 behaves as L=1.
- Back-to-back MDU ops: a new issue on the cnt==1 edge gives a continuous mdu_busy and a done pulse for the first op.
- stall_cnt updates one cycle after the stalled cycle.

## Test plan
- Forward priority: ex_mem_rd=mem_wb_rd=id_ex_rs[0]=5, both writes set -> fwd_sel[1:0]=10. Clear ex_mem_reg_write -> 01. Set rs=0 with rd=0 -> 00.
- Load-use: id_ex_mem_read=1, id_ex_rd=7, id_rs[1]=7 valid -> stall=1. Same with id_rs_valid[1]=0 -> stall=0. stall_cnt advances by 1 per stalled cycle.
- MDU latency: issue rd=9, lat=3 -> mdu_busy high 3 cycles, then mdu_done=1 with mdu_done_rd=9 for 1 cycle. id_rs[0]=9 stalls through all 4 cycles. id_ex_rs[0]=9 during done -> fwd_sel=11 even with ex_mem_rd=9.
- WAW and structural: while busy on rd=4, id_rd=4 with id_reg_write -> stall. id_is_mdu=1 -> stall until cnt==1, then stall=0. Issue on that edge -> busy stays high, done pulses for rd=4.
- Reset mid-op: issue lat=10, drop rst_n at cycle 3 -> busy=0, done never pulses, stall_cnt=0 immediately.
- Saturation: SC_W=4, hold stall 20 cycles -> stall_cnt sticks at 15.
